// File: rtl/svx32_mem_arbiter_if.sv
// Bus bundle between svx32_mem_arbiter and its two requesters (IF fetch, DS data unit) plus external memory.
// The master modport is the arbiter's view; slave is the view of the surrounding requesters and memory.
interface svx32_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              pil_if_req;
    logic [ADDR_W-1:0] piv_if_addr;
    logic              pol_if_ack;
    logic              pol_if_valid;
    logic [31:0]       pov_if_rdata;

    logic              pil_ds_req;
    logic              pil_ds_wen;
    logic [ADDR_W-1:0] piv_ds_addr;
    logic [31:0]       piv_ds_wdata;
    logic [3:0]        piv_ds_byte_sel;
    logic              pol_ds_ack;
    logic              pol_ds_valid;
    logic [31:0]       pov_ds_rdata;

    logic              pol_mem_req;
    logic              pol_mem_wen;
    logic [ADDR_W-1:0] pov_mem_addr;
    logic [31:0]       pov_mem_wdata;
    logic [3:0]        pov_mem_byte_sel;
    logic              pil_mem_ack;
    logic              pil_mem_valid;
    logic [31:0]       piv_mem_rdata;

    modport master (
        input  pil_if_req, piv_if_addr,
        output pol_if_ack, pol_if_valid, pov_if_rdata,
        input  pil_ds_req, pil_ds_wen, piv_ds_addr, piv_ds_wdata, piv_ds_byte_sel,
        output pol_ds_ack, pol_ds_valid, pov_ds_rdata,
        output pol_mem_req, pol_mem_wen, pov_mem_addr, pov_mem_wdata, pov_mem_byte_sel,
        input  pil_mem_ack, pil_mem_valid, piv_mem_rdata
    );

    modport slave (
        output pil_if_req, piv_if_addr,
        input  pol_if_ack, pol_if_valid, pov_if_rdata,
        output pil_ds_req, pil_ds_wen, piv_ds_addr, piv_ds_wdata, piv_ds_byte_sel,
        input  pol_ds_ack, pol_ds_valid, pov_ds_rdata,
        input  pol_mem_req, pol_mem_wen, pov_mem_addr, pov_mem_wdata, pov_mem_byte_sel,
        output pil_mem_ack, pil_mem_valid, piv_mem_rdata
    );
endinterface

// File: rtl/svx32_mem_arbiter.sv
// Two-requester (IF fetch / DS data) arbiter for the single svx32 memory bus, one transaction in flight.
// Define SVX32_ARB_RR_EN for round-robin tie-break; otherwise DS has fixed priority over IF.
module svx32_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic                 pil_clk,
    input  logic                 pil_rst,
    svx32_mem_arbiter_if.master  bus,
    output logic                 pol_timeout
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;
    typedef enum logic {OWN_DS = 1'b0, OWN_IF = 1'b1} owner_t;

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int WD_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t            state, state_d;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [31:0]       wdata_q;
    logic [3:0]        byte_sel_q;
    logic              timeout_q;
    logic [WD_W-1:0]   wd_cnt;

    logic              grant;
    logic              pick_ds;
    logic              abort;
    logic              own_ack;
    logic              own_valid;
    logic [31:0]       own_rdata;

`ifdef SVX32_ARB_RR_EN
    owner_t last_served;
    // On a tie the requester that was not served last wins.
    assign pick_ds = bus.pil_ds_req && (!bus.pil_if_req || last_served == OWN_IF);
`else
    assign pick_ds = bus.pil_ds_req;
`endif

    assign abort = WD_EN && (state != ST_IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    // NOTE: every signal written here gets a default first so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        grant     = 1'b0;
        own_ack   = 1'b0;
        own_valid = 1'b0;
        own_rdata = 32'h0;
        case (state)
            ST_IDLE: begin
                if (bus.pil_if_req || bus.pil_ds_req) begin
                    grant   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (abort) begin
                    own_ack   = 1'b1;
                    own_valid = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.pil_mem_ack) begin
                    own_ack = 1'b1;
                    if (wen_q) begin
                        state_d = ST_IDLE;
                    end else if (bus.pil_mem_valid) begin
                        own_valid = 1'b1;
                        own_rdata = bus.piv_mem_rdata;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (abort) begin
                    own_valid = 1'b1;
                    state_d   = ST_IDLE;
                end else if (bus.pil_mem_valid) begin
                    own_valid = 1'b1;
                    own_rdata = bus.piv_mem_rdata;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Route the owner's handshake; the non-owner side stays quiet and rdata is zero without valid.
    assign bus.pol_if_ack    = own_ack   && (owner == OWN_IF);
    assign bus.pol_if_valid  = own_valid && (owner == OWN_IF);
    assign bus.pov_if_rdata  = (owner == OWN_IF) ? own_rdata : 32'h0;
    assign bus.pol_ds_ack    = own_ack   && (owner == OWN_DS);
    assign bus.pol_ds_valid  = own_valid && (owner == OWN_DS);
    assign bus.pov_ds_rdata  = (owner == OWN_DS) ? own_rdata : 32'h0;

    assign bus.pol_mem_req      = (state == ST_REQ);
    assign bus.pol_mem_wen      = wen_q;
    assign bus.pov_mem_addr     = addr_q;
    assign bus.pov_mem_wdata    = wdata_q;
    assign bus.pov_mem_byte_sel = byte_sel_q;
    assign pol_timeout          = timeout_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge pil_clk) begin
        if (pil_rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_DS;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'h0;
            byte_sel_q  <= 4'h0;
            timeout_q   <= 1'b0;
            wd_cnt      <= '0;
`ifdef SVX32_ARB_RR_EN
            last_served <= OWN_IF;
`endif
        end else begin
            state <= state_d;
            if (grant) begin
                owner       <= pick_ds ? OWN_DS : OWN_IF;
                addr_q      <= pick_ds ? bus.piv_ds_addr : bus.piv_if_addr;
                wen_q       <= pick_ds ? bus.pil_ds_wen : 1'b0;
                wdata_q     <= pick_ds ? bus.piv_ds_wdata : 32'h0;
                byte_sel_q  <= pick_ds ? bus.piv_ds_byte_sel : 4'hF;
`ifdef SVX32_ARB_RR_EN
                last_served <= pick_ds ? OWN_DS : OWN_IF;
`endif
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
            if (!WD_EN || state == ST_IDLE || abort) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end
endmodule
